// File: rtl/cdb_arbiter.sv
// Common-data-bus writeback arbiter: one holding slot per functional unit,
// round-robin grant onto a registered CDB broadcast, flushed on jump commit.
module cdb_arbiter #(
    parameter  int NUM_FU    = 4,
    parameter  int ROB_DEPTH = 16,
    parameter  int PS_WIDTH  = 6,
    parameter  int AR_WIDTH  = 5,
    parameter  int DATA_W    = 32,
    localparam int RW        = $clog2(ROB_DEPTH),
    localparam int SW        = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NUM_FU-1:0]          fu_valid,
    output logic [NUM_FU-1:0]          fu_ready,
    input  logic [NUM_FU*RW-1:0]       fu_rob_idx,
    input  logic [NUM_FU*PS_WIDTH-1:0] fu_pd,
    input  logic [NUM_FU*AR_WIDTH-1:0] fu_rd,
    input  logic [NUM_FU*DATA_W-1:0]   fu_result,
    output logic                       cdb_valid,
    output logic [RW-1:0]              cdb_rob_idx,
    output logic [PS_WIDTH-1:0]        cdb_pd,
    output logic [AR_WIDTH-1:0]        cdb_rd,
    output logic [DATA_W-1:0]          cdb_result,
    output logic [SW-1:0]              cdb_src,
    output logic [31:0]                perf_conflicts
);

    logic [NUM_FU-1:0]   r_slot_valid;
    logic [RW-1:0]       r_slot_rob    [NUM_FU];
    logic [PS_WIDTH-1:0] r_slot_pd     [NUM_FU];
    logic [AR_WIDTH-1:0] r_slot_rd     [NUM_FU];
    logic [DATA_W-1:0]   r_slot_result [NUM_FU];
    logic [SW-1:0]       r_rr_ptr;

    logic                r_cdb_valid;
    logic [RW-1:0]       r_cdb_rob;
    logic [PS_WIDTH-1:0] r_cdb_pd;
    logic [AR_WIDTH-1:0] r_cdb_rd;
    logic [DATA_W-1:0]   r_cdb_result;
    logic [SW-1:0]       r_cdb_src;
    logic [31:0]         r_perf;

    logic [NUM_FU-1:0]   w_grant;
    logic [NUM_FU-1:0]   w_accept;
    logic                w_found;
    logic [SW-1:0]       w_win;

    function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_FU) s = s - NUM_FU;
        return SW'(s);
    endfunction

    // Scan from rr_ptr upward with wrap; first pending slot wins.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!w_found && r_slot_valid[wrap_idx(r_rr_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = wrap_idx(r_rr_ptr, k);
            end
        end
        if (w_found) w_grant[w_win] = 1'b1;
    end

    assign fu_ready = {NUM_FU{~flush}} & (~r_slot_valid | w_grant);
    assign w_accept = fu_valid & fu_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_slot_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_accept[i]) r_slot_valid[i] <= 1'b1;
                else if (w_grant[i]) r_slot_valid[i] <= 1'b0;
            end
        end
    end

    // Payload carries no reset; it is only observed behind a valid bit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_accept[i]) begin
                r_slot_rob[i]    <= fu_rob_idx[i*RW +: RW];
                r_slot_pd[i]     <= fu_pd[i*PS_WIDTH +: PS_WIDTH];
                r_slot_rd[i]     <= fu_rd[i*AR_WIDTH +: AR_WIDTH];
                r_slot_result[i] <= fu_result[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rr_ptr <= '0;
        end else if (w_found) begin
            r_rr_ptr <= (w_win == SW'(NUM_FU - 1)) ? '0 : w_win + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cdb_valid  <= 1'b0;
            r_cdb_rob    <= '0;
            r_cdb_pd     <= '0;
            r_cdb_rd     <= '0;
            r_cdb_result <= '0;
            r_cdb_src    <= '0;
        end else if (flush) begin
            r_cdb_valid <= 1'b0;
        end else if (w_found) begin
            r_cdb_valid  <= 1'b1;
            r_cdb_rob    <= r_slot_rob[w_win];
            r_cdb_pd     <= r_slot_pd[w_win];
            r_cdb_rd     <= r_slot_rd[w_win];
            r_cdb_result <= r_slot_result[w_win];
            r_cdb_src    <= w_win;
        end else begin
            r_cdb_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf <= '0;
        end else if (!flush && ($countones(r_slot_valid) > 1) && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign cdb_valid      = r_cdb_valid;
    assign cdb_rob_idx    = r_cdb_rob;
    assign cdb_pd         = r_cdb_pd;
    assign cdb_rd         = r_cdb_rd;
    assign cdb_result     = r_cdb_result;
    assign cdb_src        = r_cdb_src;
    assign perf_conflicts = r_perf;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a per-FU pending-entry model predicts each
// broadcast; a negedge monitor pops and compares whatever the CDB presents.
module tb_cdb_arbiter;
    localparam int NUM_FU = 4;
    localparam int RW     = 4;
    localparam int PSW    = 6;
    localparam int ARW    = 5;
    localparam int DW     = 32;
    localparam int SW     = 2;

    typedef struct packed {
        logic [RW-1:0]  rob;
        logic [PSW-1:0] pd;
        logic [ARW-1:0] rd;
        logic [DW-1:0]  res;
        logic [SW-1:0]  src;
    } ent_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    flush = 1'b0;
    logic [NUM_FU-1:0]       fu_valid = '0;
    logic [NUM_FU-1:0]       fu_ready;
    logic [NUM_FU*RW-1:0]    fu_rob_idx = '0;
    logic [NUM_FU*PSW-1:0]   fu_pd = '0;
    logic [NUM_FU*ARW-1:0]   fu_rd = '0;
    logic [NUM_FU*DW-1:0]    fu_result = '0;
    logic                    cdb_valid;
    logic [RW-1:0]           cdb_rob_idx;
    logic [PSW-1:0]          cdb_pd;
    logic [ARW-1:0]          cdb_rd;
    logic [DW-1:0]           cdb_result;
    logic [SW-1:0]           cdb_src;
    logic [31:0]             perf_conflicts;

    cdb_arbiter #(.NUM_FU(NUM_FU), .ROB_DEPTH(16), .PS_WIDTH(PSW), .AR_WIDTH(ARW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_rob_idx(fu_rob_idx), .fu_pd(fu_pd), .fu_rd(fu_rd), .fu_result(fu_result),
        .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_pd(cdb_pd), .cdb_rd(cdb_rd),
        .cdb_result(cdb_result), .cdb_src(cdb_src), .perf_conflicts(perf_conflicts)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    // Reference model: which FUs hold an un-broadcast completion, and whose turn it is.
    bit             m_pend [NUM_FU];
    logic [RW-1:0]  m_rob  [NUM_FU];
    logic [PSW-1:0] m_pd   [NUM_FU];
    logic [ARW-1:0] m_rd   [NUM_FU];
    logic [DW-1:0]  m_res  [NUM_FU];
    int             m_ptr = 0;
    longint         m_conf = 0;
    ent_t           exp_q [$];

    logic [RW-1:0]  t_rob [NUM_FU];
    logic [PSW-1:0] t_pd  [NUM_FU];
    logic [ARW-1:0] t_rd  [NUM_FU];
    logic [DW-1:0]  t_res [NUM_FU];

    task automatic rand_payload();
        for (int i = 0; i < NUM_FU; i++) begin
            t_rob[i] = RW'($urandom);
            t_pd[i]  = PSW'($urandom);
            t_rd[i]  = ARW'($urandom);
            t_res[i] = $urandom;
        end
    endtask

    function automatic int pick_winner();
        for (int k = 0; k < NUM_FU; k++) begin
            if (m_pend[(m_ptr + k) % NUM_FU]) return (m_ptr + k) % NUM_FU;
        end
        return -1;
    endfunction

    task automatic step(input logic [NUM_FU-1:0] v, input logic fl, input logic rs);
        int g;
        int npend;
        logic [NUM_FU-1:0] exp_rdy;
        @(negedge clk);
        fu_valid = v;
        flush    = fl;
        rst      = rs;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_rob_idx[i*RW +: RW]  = t_rob[i];
            fu_pd[i*PSW +: PSW]     = t_pd[i];
            fu_rd[i*ARW +: ARW]     = t_rd[i];
            fu_result[i*DW +: DW]   = t_res[i];
        end
        #1;
        g = pick_winner();
        for (int i = 0; i < NUM_FU; i++) exp_rdy[i] = !fl && (!m_pend[i] || g == i);
        if (mon_en) begin
            n_cmp++;
            if (fu_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL fu_ready @%0t: got %b expected %b", $time, fu_ready, exp_rdy);
            end
        end
        @(posedge clk);
        if (rs) begin
            for (int i = 0; i < NUM_FU; i++) m_pend[i] = 1'b0;
            m_ptr  = 0;
            m_conf = 0;
        end else if (fl) begin
            for (int i = 0; i < NUM_FU; i++) m_pend[i] = 1'b0;
            m_ptr = 0;
        end else begin
            npend = 0;
            for (int i = 0; i < NUM_FU; i++) npend += int'(m_pend[i]);
            if (npend > 1 && m_conf < 64'hFFFF_FFFF) m_conf++;
            if (g >= 0) begin
                exp_q.push_back('{rob: m_rob[g], pd: m_pd[g], rd: m_rd[g], res: m_res[g], src: SW'(g)});
                m_pend[g] = 1'b0;
                m_ptr = (g + 1) % NUM_FU;
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (v[i] && exp_rdy[i]) begin
                    m_pend[i] = 1'b1;
                    m_rob[i]  = t_rob[i];
                    m_pd[i]   = t_pd[i];
                    m_rd[i]   = t_rd[i];
                    m_res[i]  = t_res[i];
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            ent_t got;
            ent_t exp;
            got = '{rob: cdb_rob_idx, pd: cdb_pd, rd: cdb_rd, res: cdb_result, src: cdb_src};
            n_cmp++;
            if (cdb_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL cdb_unexpected @%0t: got src=%0d rob=%0d, expected no broadcast", $time, cdb_src, cdb_rob_idx);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL cdb_entry @%0t: got src=%0d rob=%0d pd=%0d rd=%0d res=%h, expected src=%0d rob=%0d pd=%0d rd=%0d res=%h",
                                 $time, got.src, got.rob, got.pd, got.rd, got.res, exp.src, exp.rob, exp.pd, exp.rd, exp.res);
                    end
                end
            end else if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                n_fail++;
                $display("FAIL cdb_missing @%0t: got cdb_valid=%b, expected src=%0d rob=%0d", $time, cdb_valid, exp.src, exp.rob);
            end
            n_cmp++;
            if (perf_conflicts !== 32'(m_conf)) begin
                n_fail++;
                $display("FAIL perf_conflicts @%0t: got %0d expected %0d", $time, perf_conflicts, m_conf);
            end
        end
    end

    initial begin
        for (int i = 0; i < NUM_FU; i++) m_pend[i] = 1'b0;
        rand_payload();
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        mon_en = 1'b1;

        // Reset idle: outputs zero, all slots ready
        for (int c = 0; c < 5; c++) step('0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({cdb_valid, cdb_rob_idx, cdb_pd, cdb_rd, cdb_result, cdb_src} !== '0 || fu_ready !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b rob=%0d pd=%0d rd=%0d res=%h src=%0d ready=%b, expected all zero and ready=1111",
                     cdb_valid, cdb_rob_idx, cdb_pd, cdb_rd, cdb_result, cdb_src, fu_ready);
        end

        // All four at once from rr_ptr 0
        for (int i = 0; i < NUM_FU; i++) t_rob[i] = RW'(i);
        step(4'b1111, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) step('0, 1'b0, 1'b0);

        // Single FU2 transaction
        t_rob[2] = 4'd5; t_pd[2] = 6'd9; t_rd[2] = 5'd3; t_res[2] = 32'hDEAD_BEEF;
        step(4'b0100, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) step('0, 1'b0, 1'b0);

        // FU0 and FU1 streaming together
        for (int c = 0; c < 10; c++) begin
            rand_payload();
            step(4'b0011, 1'b0, 1'b0);
        end
        for (int c = 0; c < 4; c++) step('0, 1'b0, 1'b0);

        // Flush with three slots pending, then an FU3 request
        rand_payload();
        step(4'b0111, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0);
        rand_payload();
        step(4'b1000, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) step('0, 1'b0, 1'b0);

        // rst together with flush mid-stream
        rand_payload();
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) step('0, 1'b0, 1'b0);

        // Randomized traffic with occasional flush and reset
        for (int c = 0; c < 3000; c++) begin
            rand_payload();
            step(NUM_FU'($urandom), ($urandom_range(0, 31) == 0), ($urandom_range(0, 199) == 0));
        end
        for (int c = 0; c < 8; c++) step('0, 1'b0, 1'b0);

        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d broadcasts outstanding, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
